// File: rtl/ltssm_pkg.sv
// ltssm_pkg: symbol constants, gen encodings, sender state and latched-config type for the LTSSM ordered-set sender
package ltssm_pkg;
  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam logic [7:0] G3_TS1 = 8'h1E;
  localparam logic [7:0] G3_TS2 = 8'h2D;
  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  typedef enum logic [1:0] {S_IDLE, S_EIEOS, S_SEND_TS} state_e;
  typedef struct packed {
    logic       g3;
    logic       ts2;
    logic [7:0] link;
    logic       pad_link;
    logic       pad_lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] tc;
    logic [4:0] lanes;
  } cfg_t;
endpackage

// File: rtl/os_builder.sv
// os_builder: builds one lane's 128-bit TS/EIEOS set (i_cfg, i_lane, i_eieos -> o_set)
module os_builder
  import ltssm_pkg::*;
(
  input  cfg_t         i_cfg,
  input  logic [3:0]   i_lane,
  input  logic         i_eieos,
  output logic [127:0] o_set
);
  logic [7:0]   w_s0, w_s1, w_s2, w_id;
  logic [127:0] w_ts;
  always_comb begin
    w_s0  = i_cfg.g3 ? (i_cfg.ts2 ? G3_TS2 : G3_TS1) : COM;
    w_s1  = i_cfg.pad_link ? PAD : i_cfg.link;
    w_s2  = i_cfg.pad_lane ? PAD : {4'b0, i_lane};
    w_id  = i_cfg.ts2 ? TS2_ID : TS1_ID;
    w_ts  = {{10{w_id}}, i_cfg.tc, i_cfg.rate, i_cfg.nfts, w_s2, w_s1, w_s0};
    o_set = ({1'b0, i_lane} >= i_cfg.lanes) ? '0 : i_eieos ? {8{16'hFF00}} : w_ts;
  end
endmodule

// File: rtl/tx_ltssm_os_sender.sv
// tx_ltssm_os_sender: TS1/TS2/EIEOS burst generator for 16 lanes, valid/ready out, counted bursts with finish pulse
module tx_ltssm_os_sender
  import ltssm_pkg::*;
#(
  parameter int EIEOS_INTERVAL = 32,
  parameter int COUNT_WIDTH    = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [2:0]             gen,
  input  logic                   osType,
  input  logic [COUNT_WIDTH-1:0] targetCount,
  input  logic [7:0]             linkNumber,
  input  logic                   padLink,
  input  logic                   padLane,
  input  logic [7:0]             nFts,
  input  logic [7:0]             rateId,
  input  logic [7:0]             trainingControl,
  input  logic [4:0]             numberOfDetectedLanes,
  input  logic                   txReady,
  output logic [2047:0]          orderedSets,
  output logic [15:0]            kMask,
  output logic [1:0]             syncHeader,
  output logic                   validOrderedSets,
  output logic                   busy,
  output logic                   finish,
  output logic [COUNT_WIDTH-1:0] sentCount
);
  localparam int SW = $clog2(EIEOS_INTERVAL + 1);
  state_e                 r_state, w_next;
  cfg_t                   r_cfg, w_cfg_in, w_cfg_n;
  logic [COUNT_WIDTH-1:0] r_target, w_sent_inc, w_sent_n;
  logic [SW-1:0]          r_since, w_since_inc, w_since_n;
  logic                   w_launch, w_hs, w_ts_hs, w_done, w_eie, w_idle_n;
  logic [15:0]            w_kmask_n;
  logic [1:0]             w_sync_n;
  logic [2047:0]          w_os;
  assign w_cfg_in = '{g3: gen >= GEN3, ts2: osType, link: linkNumber, pad_link: padLink,
                      pad_lane: padLane, nfts: nFts, rate: rateId, tc: trainingControl,
                      lanes: numberOfDetectedLanes};
  assign w_launch    = start & ~stop & (r_state == S_IDLE);
  assign w_cfg_n     = w_launch ? w_cfg_in : r_cfg;
  assign w_hs        = validOrderedSets & txReady;
  assign w_ts_hs     = w_hs & (r_state == S_SEND_TS);
  assign w_sent_inc  = &sentCount ? sentCount : sentCount + 1'b1;
  assign w_since_inc = r_since + 1'b1;
  assign w_done      = w_ts_hs & (r_target != '0) & (w_sent_inc == r_target);
  // completion outranks EIEOS insertion on the same handshake
  assign w_eie       = w_ts_hs & ~w_done & r_cfg.g3 & (w_since_inc == SW'(EIEOS_INTERVAL));
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (stop) w_next = S_IDLE;
    else if (r_state == S_IDLE) w_next = w_launch ? (w_cfg_in.g3 ? S_EIEOS : S_SEND_TS) : S_IDLE;
    else if (w_hs) w_next = (r_state == S_EIEOS) ? S_SEND_TS : w_done ? S_IDLE : w_eie ? S_EIEOS : S_SEND_TS;
  end
  always_comb begin
    w_idle_n  = (w_next == S_IDLE);
    w_kmask_n = (w_idle_n || w_cfg_n.g3) ? 16'h0 : {13'b0, w_cfg_n.pad_lane, w_cfg_n.pad_link, 1'b1};
    w_sync_n  = (!w_idle_n && w_cfg_n.g3) ? 2'b01 : 2'b00;
    w_sent_n  = w_launch ? '0 : w_ts_hs ? w_sent_inc : sentCount;
    w_since_n = (w_launch || w_eie) ? '0 : (w_ts_hs && r_cfg.g3) ? w_since_inc : r_since;
  end
  // the next set is built from next-cycle state and config so every output is a flop
  for (genvar i = 0; i < 16; i++) begin : g_lane
    os_builder u_builder (
      .i_cfg  (w_cfg_n),
      .i_lane (4'(i)),
      .i_eieos(w_next == S_EIEOS),
      .o_set  (w_os[i*128 +: 128])
    );
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg            <= '0;
      r_target         <= '0;
      r_since          <= '0;
      orderedSets      <= '0;
      kMask            <= '0;
      syncHeader       <= '0;
      validOrderedSets <= 1'b0;
      busy             <= 1'b0;
      finish           <= 1'b0;
      sentCount        <= '0;
    end else begin
      r_cfg            <= w_cfg_n;
      r_target         <= w_launch ? targetCount : r_target;
      r_since          <= w_since_n;
      orderedSets      <= w_idle_n ? '0 : w_os;
      kMask            <= w_kmask_n;
      syncHeader       <= w_sync_n;
      validOrderedSets <= ~w_idle_n;
      busy             <= ~w_idle_n;
      finish           <= w_done & ~stop;
      sentCount        <= w_sent_n;
    end
  end
endmodule

// File: doc/tx_ltssm_os_sender.md
# tx_ltssm_os_sender

Transmit-side ordered-set generator for the LTSSM. It pairs with the receive-side checker and builds TS1/TS2 ordered sets, plus EIEOS at 8 GT/s, for all 16 lanes. It sends them to the PIPE transmit datapath over a valid/ready handshake, counts accepted sets, and pulses `finish` when the requested number has been sent. The LTSSM master controller drives it once per substate.

## Interface
Parameters:
- `EIEOS_INTERVAL`, 32: TS sets between EIEOS insertions at Gen3.
- `COUNT_WIDTH`, 11: width of target and sent counters.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: **synchronous, active-low** reset.
- `start`, in, 1: one-cycle pulse that launches a burst. Ignored while `busy`.
- `stop`, in, 1: aborts the burst.
- `gen`, in, 3: 1=2.5, 2=5, 3=8 GT/s. Latched at `start`.
- `osType`, in, 1: 0=TS1, 1=TS2. Latched.
- `targetCount`, in, COUNT_WIDTH: number of TS sets to send. 0 means continuous until `stop`. Latched.
- `linkNumber`, in, 8: latched.
- `padLink`, `padLane`, in, 1 each: send PAD instead of link/lane number. Latched.
- `nFts`, `rateId`, `trainingControl`, in, 8 each: latched.
- `numberOfDetectedLanes`, in, 5: active lanes, 1..16. Latched.
- `txReady`, in, 1: downstream accepts the current set.
- `orderedSets`, out, 2048: lane i occupies [128i+127:128i]. Symbol 0 is in the LSB byte.
- `kMask`, out, 16: K-symbol flags, common to all lanes. Gen1/2 only; 0 at Gen3.
- `syncHeader`, out, 2: 2'b01 at Gen3, 2'b00 otherwise.
- `validOrderedSets`, out, 1.
- `busy`, out, 1.
- `finish`, out, 1: one-cycle pulse.
- `sentCount`, out, COUNT_WIDTH: TS sets accepted in this burst. EIEOS excluded.

## Operation
- **States:** IDLE, EIEOS, SEND_TS.
- **IDLE → EIEOS:** on `start` when latched `gen`=3.
- **IDLE → SEND_TS:** on `start` when latched `gen`<3.
- **EIEOS → SEND_TS:** on handshake (`validOrderedSets` & `txReady`).
- **SEND_TS, on handshake:**
  - `sentCount`++ and `sinceEieos`++.
  - If `targetCount`≠0 and the new count equals `targetCount`: pulse `finish` and go to IDLE. This takes priority over EIEOS insertion.
  - Else if gen=3 and `sinceEieos` reaches EIEOS_INTERVAL: clear `sinceEieos` and go to EIEOS.
- **stop**, in any state: go to IDLE next cycle, drop valid, no `finish`. This is the only case where a valid set is withdrawn without a handshake.
- `start` and `stop` in the same cycle: `stop` wins and nothing launches.
- `sentCount` saturates at all-ones in continuous mode. The EIEOS cadence keeps running.
- `sentCount` clears at `start` and holds after `finish` until the next `start`.
- **Gen1/2 TS, per active lane:**
  - Sym0: COM 0xBC (K).
  - Sym1: link number, or PAD 0xF7 (K).
  - Sym2: lane index i, or PAD (K).
  - Sym3: nFts. Sym4: rateId. Sym5: trainingControl.
  - Sym6–15: 0x4A (TS1) or 0x45 (TS2).
  - `kMask` = 0x0001, plus bit1 if padLink, plus bit2 if padLane.
- **Gen3 TS:** Sym0 = 0x1E (TS1) or 0x2D (TS2). Sym1–5 as above with PAD=0xF7 and no K. Sym6–15 = 0x4A (TS1) or 0x45 (TS2).
- **Gen3 EIEOS:** even symbols 0x00, odd symbols 0xFF.
- Lanes with index ≥ `numberOfDetectedLanes` carry all zeros.

## Timing
- All outputs are registered.
- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Latency:** `start` at cycle t gives `validOrderedSets` at t+1.
- `orderedSets`, `kMask` and `syncHeader` hold stable while valid and not ready.
- On handshake at cycle t, the next set is presented at t+1, so back-to-back sets run at one per cycle when `txReady` is held high.
- `finish` is asserted at t+1 after the final handshake at t, together with `busy`=0 and `validOrderedSets`=0.
- Reset mid-burst: the next cycle shows reset values and no `finish`.

## Structure
- **Package `ltssm_pkg`:**
  - Symbol constants: COM 0xBC, PAD 0xF7, TS1_ID 0x4A, TS2_ID 0x45, G3_TS1 0x1E, G3_TS2 0x2D.
  - Sender state enum.
  - Gen encodings.
- **Sub-module `os_builder`:** combinational. It builds one lane's 128-bit set from the latched config, the lane index and an EIEOS/TS select. It is instantiated 16 times in a generate loop. The FSM, counters and output registers stay in the top.

## Test plan
1. Gen1, TS1, target=16, link=5, 4 lanes, txReady=1:
   - 16 consecutive valid cycles.
   - Lane 2 bytes: BC 05 02 … 4A×10.
   - `kMask`=0x0001. Lanes 4–15 zero.
   - `finish` one cycle later, `sentCount`=16.
2. Gen3, TS2, target=70:
   - First set is EIEOS (00/FF, syncHeader 01).
   - EIEOS is also inserted after TS #32 and #64.
   - 73 handshakes total, `finish` once, `sentCount`=70.
3. Backpressure: txReady toggles 1,0,0,1 during a burst. Data holds during the stall and no count increments while ready is low.
4. Gen2, TS1, padLink=padLane=1: Sym1=Sym2=0xF7 and `kMask`=0x0007.
5. Continuous mode (target=0):
   - `stop` after 100 sets: valid low next cycle, no `finish`.
   - A second `start` asserted while busy is ignored.
6. Reset asserted low mid-burst: all outputs 0 the next cycle. A subsequent `start` restarts with `sentCount`=0.
